stack_op_issuer: RTL and testbench
==================================

# stack_op_issuer

Command-side driver for the operand stack. It accepts decoded stack operations over a valid/ready handshake and splits pops of up to 7 entries into chunks of at most 3 per cycle. It drives the stack's push/pop command port, keeps a shadow occupancy count, captures the top-of-stack operand window, and traps on underflow or overflow before issuing anything. It sits between the instruction decoder and the operand stack, on the command side of the stack interface.

## Interface
- ST_WIDTH, 32: entry width in bits.
- ST_DEPTH, 16: stack depth. The stack saturates at ST_DEPTH-1 valid entries.
- ST_LOG2_DEPTH, 4: log2(ST_DEPTH). Width of the occupancy count.
- POP_MAX, 3: maximum pops per stack command. Fixed at 3.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  operation offered
- op_ready  out  1  operation accepted when op_valid & op_ready
- op_pop  in  3  entries to pop, 0..7
- op_push  in  1  push op_data after the pops
- op_data  in  ST_WIDTH  value to push
- st_push_num  out  1  stack push command
- st_pop_num  out  2  stack pop command, 0..3
- st_push_data  out  ST_WIDTH  stack push data
- st_pop_window  in  POP_MAX*ST_WIDTH  stack top 3 entries; [ST_WIDTH-1:0] is the top
- opnd  out  POP_MAX*ST_WIDTH  captured operand window
- opnd_valid  out  1  one-cycle pulse: opnd updated
- depth  out  ST_LOG2_DEPTH  shadow occupancy
- trap  out  1  trap state active
- trap_code  out  2  00 none, 01 underflow, 10 overflow
- trap_clr  in  1  leave trap state

## Operation
- FSM states: IDLE, ISSUE, TRAP.
- IDLE:
  - op_ready=1.
  - On handshake, register op_pop, op_push and op_data, then run the checks below.
  - Underflow: if op_pop > depth, go to TRAP with trap_code=01.
  - Overflow: else if op_push=1 and (depth - op_pop) == ST_DEPTH-1, go to TRAP with trap_code=10.
  - Otherwise go to ISSUE with rem=op_pop.
- ISSUE, one stack command per cycle:
  - chunk = min(rem,3); st_pop_num=chunk.
  - The last cycle is the one where rem ≤ 3. In that cycle st_push_num=op_push and st_push_data=op_data; otherwise st_push_num=0.
  - depth <= depth - chunk + st_push_num; rem <= rem - chunk.
  - After the last cycle, return to IDLE.
  - An op with op_pop=0 (push-only, or a nop) uses exactly one ISSUE cycle.
- Operand capture:
  - In the first ISSUE cycle of an op with op_pop>0, opnd <= st_pop_window.
  - opnd_valid pulses high for the following cycle.
  - opnd holds its value until the next capture.
- TRAP:
  - trap=1, op_ready=0, st_pop_num=0, st_push_num=0; depth unchanged.
  - trap_clr=1 returns to IDLE and clears trap_code to 00.
  - trap_clr in IDLE or ISSUE is ignored.
- Outside ISSUE, st_pop_num=0, st_push_num=0 and st_push_data=0.
- Width rules:
  - depth never exceeds ST_DEPTH-1 and never goes below 0, guaranteed by the checks.
  - Compare with op_pop zero-extended to ST_LOG2_DEPTH+1 bits.

## Timing
- Reset values (rst high, asynchronous):
  - state=IDLE.
  - op_ready=1, depth=0, trap=0, trap_code=00.
  - opnd=0, opnd_valid=0.
  - All st_* outputs 0.
- Integration: rst must reset the stack in the same cycle (stack reset is inverted from rst), so depth=0 matches an empty stack.
- rst asserted mid-ISSUE aborts the op immediately. No partial command is emitted after reset.
- Latency: op accepted at edge T → ISSUE cycles T+1..T+k, where k = max(1, ceil(op_pop/3)). op_ready returns high in cycle T+k+1.
- Throughput: one op per k+1 cycles.
- A trap is raised one cycle after acceptance: trap=1 from T+1.
- The stack applies each command at the same edge that updates depth, so depth always equals the stack's pointer.

## Test plan
- Reset: assert rst for 2 cycles → op_ready=1, depth=0, trap=0, st_push_num=0, st_pop_num=0.
- Push 0xA, 0xB, 0xC (op_pop=0, op_push=1 each) → one ISSUE cycle each with st_push_num=1 and matching data; depth=3.
  - Then op_pop=2, op_push=1, op_data=0x5 → a single cycle with st_pop_num=2, st_push_num=1.
  - opnd = {0xA, 0xB, 0xC}, with 0xC at bits [31:0]; opnd_valid pulses once; depth=2.
- From depth=10, op_pop=7, op_push=1 → ISSUE sequence st_pop_num = 3, 3, 1.
  - Push occurs only in the third cycle.
  - op_ready is low for 3 cycles; final depth=4.
- From depth=2, op_pop=3 → trap=1, trap_code=01, no st_* activity, depth=2.
  - op_valid is ignored while trapped.
  - trap_clr → IDLE, trap_code=00.
- From depth=15, op_pop=0, op_push=1 → trap_code=10, no push issued.
  - From depth=15, op_pop=1, op_push=1 → accepted, depth stays 15.
- From depth=9, op_pop=7, assert rst during the second ISSUE cycle → all outputs at reset values immediately, depth=0, no further st_* commands.

Source files
------------

// File: rtl/stack_op_issuer.sv
// stack_op_issuer
// Command-side driver for the operand stack. Accepts decoded stack operations
// over valid/ready, splits pops of up to 7 entries into stack commands of at
// most POP_MAX pops each, keeps a shadow occupancy count, captures the
// top-of-stack operand window and traps on underflow/overflow before any
// command is issued.
module stack_op_issuer #(
  parameter int ST_WIDTH      = 32,
  parameter int ST_DEPTH      = 16,
  parameter int ST_LOG2_DEPTH = 4,
  parameter int POP_MAX       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [2:0]                  op_pop,
  input  logic                        op_push,
  input  logic [ST_WIDTH-1:0]         op_data,
  output logic                        st_push_num,
  output logic [1:0]                  st_pop_num,
  output logic [ST_WIDTH-1:0]         st_push_data,
  input  logic [POP_MAX*ST_WIDTH-1:0] st_pop_window,
  output logic [POP_MAX*ST_WIDTH-1:0] opnd,
  output logic                        opnd_valid,
  output logic [ST_LOG2_DEPTH-1:0]    depth,
  output logic                        trap,
  output logic [1:0]                  trap_code,
  input  logic                        trap_clr
);

  // Checks run one bit wider than the occupancy count so that op_pop can
  // exceed the current depth without wrapping.
  localparam int CW = ST_LOG2_DEPTH + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(ST_DEPTH - 1);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_UNDER = 2'b01;
  localparam logic [1:0] CODE_OVER  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t                state;
  logic [2:0]            rem;         // pops still to be issued, including the current command
  logic                  push_q;      // registered op_push
  logic [ST_WIDTH-1:0]   data_q;      // registered op_data
  logic                  first;       // current ISSUE cycle is the first of the op

  logic                  accept;
  logic [CW-1:0]         pop_ext;
  logic [CW-1:0]         depth_ext;
  logic [CW-1:0]         room_after_pop;
  logic                  underflow;
  logic                  overflow;
  logic [2:0]            rem_next;

  // Number of pops carried by one stack command for a given remaining count.
  function automatic logic [1:0] chunk_of(input logic [2:0] r);
    if (r > 3'd3) begin
      chunk_of = 2'd3;
    end else begin
      chunk_of = r[1:0];
    end
  endfunction

  // The command carrying the push is the one that finishes the pops.
  function automatic logic is_last(input logic [2:0] r);
    is_last = (r <= 3'd3);
  endfunction

  // Acceptance, trap checks and the remaining-pop count after this command.
  always_comb begin
    accept         = (state == IDLE) && op_valid;
    pop_ext        = CW'(op_pop);
    depth_ext      = CW'(depth);
    room_after_pop = depth_ext - pop_ext;
    underflow      = (pop_ext > depth_ext);
    overflow       = 1'b0;
    if (!underflow && op_push && (room_after_pop == FULL_LEVEL)) begin
      overflow = 1'b1;
    end else begin
      overflow = 1'b0;
    end
    rem_next       = rem - {1'b0, st_pop_num};
  end

  // Control FSM with registered stack commands, occupancy, capture and trap state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rem          <= 3'd0;
      push_q       <= 1'b0;
      data_q       <= '0;
      first        <= 1'b0;
      op_ready     <= 1'b1;
      st_push_num  <= 1'b0;
      st_pop_num   <= 2'd0;
      st_push_data <= '0;
      opnd         <= '0;
      opnd_valid   <= 1'b0;
      depth        <= '0;
      trap         <= 1'b0;
      trap_code    <= CODE_NONE;
    end else begin
      opnd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rem      <= op_pop;
            push_q   <= op_push;
            data_q   <= op_data;
            op_ready <= 1'b0;
            if (underflow) begin
              state     <= TRAP;
              trap      <= 1'b1;
              trap_code <= CODE_UNDER;
            end else if (overflow) begin
              state     <= TRAP;
              trap      <= 1'b1;
              trap_code <= CODE_OVER;
            end else begin
              state      <= ISSUE;
              first      <= 1'b1;
              st_pop_num <= chunk_of(op_pop);
              if (is_last(op_pop)) begin
                st_push_num  <= op_push;
                st_push_data <= op_push ? op_data : '0;
              end else begin
                st_push_num  <= 1'b0;
                st_push_data <= '0;
              end
            end
          end else begin
            op_ready <= 1'b1;
          end
        end

        ISSUE: begin
          // The stack applies the command at this same edge.
          depth <= depth - ST_LOG2_DEPTH'(st_pop_num) + ST_LOG2_DEPTH'(st_push_num);
          first <= 1'b0;
          // The window still shows the pre-pop top entries in the first cycle.
          if (first && (rem != 3'd0)) begin
            opnd       <= st_pop_window;
            opnd_valid <= 1'b1;
          end else begin
            opnd       <= opnd;
          end
          if (is_last(rem)) begin
            state        <= IDLE;
            rem          <= 3'd0;
            op_ready     <= 1'b1;
            st_pop_num   <= 2'd0;
            st_push_num  <= 1'b0;
            st_push_data <= '0;
          end else begin
            rem        <= rem_next;
            st_pop_num <= chunk_of(rem_next);
            if (is_last(rem_next)) begin
              st_push_num  <= push_q;
              st_push_data <= push_q ? data_q : '0;
            end else begin
              st_push_num  <= 1'b0;
              st_push_data <= '0;
            end
          end
        end

        TRAP: begin
          st_pop_num   <= 2'd0;
          st_push_num  <= 1'b0;
          st_push_data <= '0;
          if (trap_clr) begin
            state     <= IDLE;
            trap      <= 1'b0;
            trap_code <= CODE_NONE;
            op_ready  <= 1'b1;
          end else begin
            op_ready  <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          rem          <= 3'd0;
          op_ready     <= 1'b1;
          st_pop_num   <= 2'd0;
          st_push_num  <= 1'b0;
          st_push_data <= '0;
          trap         <= 1'b0;
          trap_code    <= CODE_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_op_issuer.sv
// Testbench for stack_op_issuer: a behavioural operand stack follows the
// issued commands and supplies the top-of-stack window; a table of ops with
// hand-computed results drives the main flow, followed by hand-written trap
// and mid-op reset sequences.
module tb_stack_op_issuer;

  localparam int W = 32;
  localparam int D = 16;
  localparam int L = 4;
  localparam int P = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           op_valid;
  logic           op_ready;
  logic [2:0]     op_pop;
  logic           op_push;
  logic [W-1:0]   op_data;
  logic           st_push_num;
  logic [1:0]     st_pop_num;
  logic [W-1:0]   st_push_data;
  logic [P*W-1:0] st_pop_window;
  logic [P*W-1:0] opnd;
  logic           opnd_valid;
  logic [L-1:0]   depth;
  logic           trap;
  logic [1:0]     trap_code;
  logic           trap_clr;

  int checks = 0;
  int errors = 0;

  stack_op_issuer #(.ST_WIDTH(W), .ST_DEPTH(D), .ST_LOG2_DEPTH(L), .POP_MAX(P)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_pop(op_pop), .op_push(op_push), .op_data(op_data),
    .st_push_num(st_push_num), .st_pop_num(st_pop_num), .st_push_data(st_push_data),
    .st_pop_window(st_pop_window), .opnd(opnd), .opnd_valid(opnd_valid),
    .depth(depth), .trap(trap), .trap_code(trap_code), .trap_clr(trap_clr)
  );

  always #5 clk = ~clk;

  // Behavioural operand stack: pops then push, applied at the command edge.
  logic [W-1:0] mem [0:D-1];
  int sp;
  int sp_after_pop;
  assign sp_after_pop = sp - int'(st_pop_num);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
    end else begin
      if (st_push_num) mem[sp_after_pop[3:0]] <= st_push_data;
      sp <= sp_after_pop + int'(st_push_num);
    end
  end

  always_comb begin
    st_pop_window = '0;
    for (int i = 0; i < P; i++) begin
      int idx;
      idx = sp - 1 - i;
      if (sp > i) st_pop_window[i*W +: W] = mem[idx[3:0]];
    end
  end

  task automatic chk(input string name, input logic [P*W-1:0] act, input logic [P*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]     pop;
    logic           push;
    logic [W-1:0]   data;
    int             exp_k;
    int             exp_depth;
    logic           chk_opnd;
    logic [P*W-1:0] exp_opnd;
  } vec_t;

  vec_t vecs[14];

  // Offer one op at a negedge and follow its ISSUE cycles, comparing each
  // stack command against min(rem,3) and a push only in the last command.
  task automatic run_op(input vec_t v);
    int rem;
    int cyc;
    int nval;
    int ch;
    logic exp_push;
    chk("ready_before_op", op_ready, 1);
    op_pop = v.pop; op_push = v.push; op_data = v.data; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    rem = int'(v.pop); cyc = 0; nval = 0;
    while (!op_ready && cyc < 8) begin
      ch = (rem > 3) ? 3 : rem;
      exp_push = (rem <= 3) ? v.push : 1'b0;
      chk("st_pop_num", st_pop_num, ch);
      chk("st_push_num", st_push_num, exp_push);
      chk("st_push_data", st_push_data, exp_push ? v.data : 32'h0);
      chk("trap_in_issue", trap, 0);
      if (opnd_valid) nval++;
      rem = rem - ch;
      cyc++;
      @(negedge clk);
    end
    if (opnd_valid) nval++;
    chk("issue_cycles", cyc, v.exp_k);
    chk("depth_after_op", depth, v.exp_depth);
    chk("opnd_valid_pulses", nval, (v.pop != 3'd0) ? 1 : 0);
    chk("idle_no_pop", st_pop_num, 0);
    if (v.chk_opnd) chk("opnd", opnd, v.exp_opnd);
  endtask

  // Offer an op that must trap; hold op_valid while trapped, then clear.
  task automatic trap_seq(input logic [2:0] pop, input logic push, input logic [1:0] code, input int exp_depth);
    op_pop = pop; op_push = push; op_data = 32'hDEAD; op_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("trap", trap, 1);
      chk("trap_code", trap_code, code);
      chk("trap_ready", op_ready, 0);
      chk("trap_pop", st_pop_num, 0);
      chk("trap_push", st_push_num, 0);
      chk("trap_depth", depth, exp_depth);
      @(negedge clk);
    end
    op_valid = 1'b0;
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    chk("clr_trap", trap, 0);
    chk("clr_code", trap_code, 0);
    chk("clr_ready", op_ready, 1);
    chk("clr_depth", depth, exp_depth);
  endtask

  function automatic vec_t mk(input logic [2:0] pop, input logic push, input logic [W-1:0] data,
                              input int k, input int dep, input logic co, input logic [P*W-1:0] eo);
    vec_t v;
    v.pop = pop; v.push = push; v.data = data; v.exp_k = k; v.exp_depth = dep;
    v.chk_opnd = co; v.exp_opnd = eo;
    return v;
  endfunction

  initial begin
    vec_t v;
    // Stack after each row: [A] [A,B] [A,B,C] [A,5] [A,5,10..17] [A,5,10,77] [A,5]
    vecs[0]  = mk(3'd0, 1'b1, 32'hA, 1, 1, 1'b0, '0);
    vecs[1]  = mk(3'd0, 1'b1, 32'hB, 1, 2, 1'b0, '0);
    vecs[2]  = mk(3'd0, 1'b1, 32'hC, 1, 3, 1'b0, '0);
    vecs[3]  = mk(3'd2, 1'b1, 32'h5, 1, 2, 1'b1, {32'hA, 32'hB, 32'hC});
    for (int i = 0; i < 8; i++) vecs[4+i] = mk(3'd0, 1'b1, 32'h10 + i, 1, 3 + i, 1'b0, '0);
    vecs[12] = mk(3'd7, 1'b1, 32'h77, 3, 4, 1'b1, {32'h15, 32'h16, 32'h17});
    vecs[13] = mk(3'd2, 1'b0, 32'h0, 1, 2, 1'b1, {32'h5, 32'h10, 32'h77});

    rst = 1'b1; op_valid = 1'b0; op_pop = 3'd0; op_push = 1'b0; op_data = '0; trap_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", op_ready, 1);
    chk("rst_depth", depth, 0);
    chk("rst_trap", trap, 0);
    chk("rst_code", trap_code, 0);
    chk("rst_push", st_push_num, 0);
    chk("rst_pop", st_pop_num, 0);
    chk("rst_opnd_valid", opnd_valid, 0);
    chk("rst_opnd", opnd, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

    // Underflow at depth 2.
    trap_seq(3'd3, 1'b0, 2'b01, 2);
    chk("opnd_held_after_trap", opnd, {32'h5, 32'h10, 32'h77});

    // Fill to depth 15, then a push-only op must overflow.
    for (int i = 0; i < 13; i++) run_op(mk(3'd0, 1'b1, 32'h100 + i, 1, 3 + i, 1'b0, '0));
    trap_seq(3'd0, 1'b1, 2'b10, 15);
    // Pop one and push one at full depth is legal.
    run_op(mk(3'd1, 1'b1, 32'h99, 1, 15, 1'b1, {32'h10A, 32'h10B, 32'h10C}));
    run_op(mk(3'd6, 1'b0, 32'h0, 2, 9, 1'b1, {32'h10A, 32'h10B, 32'h99}));

    // Reset during the second ISSUE cycle of a 7-pop op.
    op_pop = 3'd7; op_push = 1'b1; op_data = 32'hEE; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("abort_issue1_pop", st_pop_num, 3);
    @(negedge clk);
    chk("abort_issue2_pop", st_pop_num, 3);
    rst = 1'b1;
    #1;
    chk("abort_pop", st_pop_num, 0);
    chk("abort_push", st_push_num, 0);
    chk("abort_data", st_push_data, 0);
    chk("abort_depth", depth, 0);
    chk("abort_ready", op_ready, 1);
    chk("abort_opnd", opnd, 0);
    chk("abort_opnd_valid", opnd_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_pop", st_pop_num, 0);
      chk("post_abort_push", st_push_num, 0);
      chk("post_abort_depth", depth, 0);
      chk("post_abort_ready", op_ready, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
